// File: rtl/stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer_if
//  Description : Memory / datapath handshake bundle between the stage
//                sequencer (master) and the instruction/data memory plus the
//                IR/PC datapath (slave).
//                  opcode  - IR opcode field, valid from DECODE onward
//                  mem_ack - memory completion, meaningful only while mem_req=1
//                  mem_req - memory access request
//                  ir_load - load IR from the memory bus
//                  pc_inc  - increment PC
//  Revision    : 1.0 - initial release
// ============================================================================
interface stage_sequencer_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           mem_ack;
    logic           mem_req;
    logic           ir_load;
    logic           pc_inc;

    modport master (
        input  opcode,
        input  mem_ack,
        output mem_req,
        output ir_load,
        output pc_inc
    );

    modport slave (
        output opcode,
        output mem_ack,
        input  mem_req,
        input  ir_load,
        input  pc_inc
    );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer
//  Description : Control FSM stepping the 3-stage processor through
//                FETCH -> DECODE -> EXEC -> INCR, with free-run and
//                single-step operation, HALT detection, memory-wait timeout
//                and a retired-instruction counter.
//  Ports       : clk      - system clock, rising edge
//                clr_n    - synchronous active-low clear
//                run      - level, continuous execution
//                step     - pulse, execute one instruction from IDLE
//                bus      - memory/datapath handshake (master side)
//                f/d/e/i  - one-hot phase strobes
//                busy     - any state other than IDLE, HALT, ERR
//                halted   - HALT state
//                err      - memory timeout state
//                retired  - completed instruction count (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int             OPW     = 4,
    parameter logic [OPW-1:0] HALT_OP = OPW'(4'hF),
    parameter int             TMO_W   = 4,
    parameter int             CNT_W   = 16
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               run,
    input  logic               step,
    stage_sequencer_if.master  bus,
    output logic               f,
    output logic               d,
    output logic               e,
    output logic               i,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_incr   = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;
    localparam logic [2:0] c_st_err    = 3'd6;

    // A wait cycle seen while the counter already holds this value is the
    // (2**TMO_W-1)-th consecutive cycle without ack, so it trips the timeout.
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'((2 ** TMO_W) - 2);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [TMO_W-1:0] r_tmo;
    logic             r_step_mode;
    logic [CNT_W-1:0] r_retired;
    logic             w_mem_op;
    logic             w_waiting;

    // MSB of the opcode marks a memory-access instruction.
    assign w_mem_op = bus.opcode[OPW-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_waiting = 1'b0;
        case (r_state)
            c_st_idle: begin
                // run and step both lead to FETCH; which one won is
                // remembered in r_step_mode.
                if (run || step) begin
                    w_next = c_st_fetch;
                end
            end
            c_st_fetch: begin
                w_waiting = 1'b1;
                if (bus.mem_ack) begin
                    w_next = c_st_decode;
                end else if (r_tmo == c_tmo_last) begin
                    w_next = c_st_err;
                end
            end
            c_st_decode: begin
                w_next = (bus.opcode == HALT_OP) ? c_st_halt : c_st_exec;
            end
            c_st_exec: begin
                if (!w_mem_op) begin
                    w_next = c_st_incr;
                end else begin
                    w_waiting = 1'b1;
                    if (bus.mem_ack) begin
                        w_next = c_st_incr;
                    end else if (r_tmo == c_tmo_last) begin
                        w_next = c_st_err;
                    end
                end
            end
            c_st_incr: begin
                w_next = (run && !r_step_mode) ? c_st_fetch : c_st_idle;
            end
            c_st_halt: w_next = c_st_halt;
            c_st_err:  w_next = c_st_err;
            default:   w_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout counter, step-mode flag, retired counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_tmo       <= '0;
            r_step_mode <= 1'b0;
            r_retired   <= '0;
        end else begin
            // Cleared on every state change, so each wait state starts fresh.
            if ((w_next != r_state) || !w_waiting) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            // run has priority over step when leaving IDLE.
            if ((r_state == c_st_idle) && (w_next == c_st_fetch)) begin
                r_step_mode <= ~run;
            end else if ((r_state == c_st_incr) && (w_next == c_st_idle)) begin
                r_step_mode <= 1'b0;
            end

            if (r_state == c_st_incr) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        f           = (r_state == c_st_fetch);
        d           = (r_state == c_st_decode);
        e           = (r_state == c_st_exec);
        i           = (r_state == c_st_incr);
        bus.mem_req = (r_state == c_st_fetch) || ((r_state == c_st_exec) && w_mem_op);
        // IR captures the fetched word in the ack cycle itself.
        bus.ir_load = (r_state == c_st_fetch) && bus.mem_ack;
        bus.pc_inc  = (r_state == c_st_incr);
        busy        = (r_state != c_st_idle) && (r_state != c_st_halt) &&
                      (r_state != c_st_err);
        halted      = (r_state == c_st_halt);
        err         = (r_state == c_st_err);
    end

    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Self-checking bench for stage_sequencer. A table of
//                per-cycle {inputs, expected outputs} records holds the
//                directed scenarios plus randomized instruction streams
//                produced by an instruction-level model; a second instance
//                with a narrow counter exercises retired-count wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

    // Expected output vector: {f,d,e,i,mem_req,ir_load,pc_inc,busy,halted,err}
    localparam logic [9:0] X_IDLE = 10'b0000000000;
    localparam logic [9:0] X_F    = 10'b1000100100;
    localparam logic [9:0] X_FA   = 10'b1000110100;
    localparam logic [9:0] X_D    = 10'b0100000100;
    localparam logic [9:0] X_EA   = 10'b0010000100;
    localparam logic [9:0] X_EM   = 10'b0010100100;
    localparam logic [9:0] X_I    = 10'b0001001100;
    localparam logic [9:0] X_H    = 10'b0000000010;
    localparam logic [9:0] X_ERR  = 10'b0000000001;

    typedef struct {
        bit          pre_rst;
        logic        clr_n;
        logic        run;
        logic        step;
        logic        ack;
        logic [3:0]  op;
        logic [9:0]  exp;
        logic [15:0] ret;
        int          tid;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        clr_n, run, step;
    logic        f, d, e, i, busy, halted, err;
    logic [15:0] retired;
    stage_sequencer_if #(.OPW(4)) bus();

    stage_sequencer #(.OPW(4), .HALT_OP(4'hF), .TMO_W(4), .CNT_W(16)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .step(step), .bus(bus),
        .f(f), .d(d), .e(e), .i(i), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    // Narrow-counter instance for the wrap scenario
    logic       clr_n_w, run_w, step_w;
    logic       f_w, d_w, e_w, i_w, busy_w, halted_w, err_w;
    logic [1:0] retired_w;
    stage_sequencer_if #(.OPW(4)) bus_w();

    stage_sequencer #(.OPW(4), .HALT_OP(4'hF), .TMO_W(4), .CNT_W(2)) dut_w (
        .clk(clk), .clr_n(clr_n_w), .run(run_w), .step(step_w), .bus(bus_w),
        .f(f_w), .d(d_w), .e(e_w), .i(i_w), .busy(busy_w), .halted(halted_w),
        .err(err_w), .retired(retired_w)
    );

    function automatic vec_t mk(input bit pr, input logic cn, input logic rn,
                                input logic st, input logic ak, input logic [3:0] op,
                                input logic [9:0] ex, input logic [15:0] rt, input int tid);
        vec_t v;
        v.pre_rst = pr; v.clr_n = cn; v.run = rn; v.step = st; v.ack = ak;
        v.op = op; v.exp = ex; v.ret = rt; v.tid = tid;
        return v;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
    endfunction

    // Directed scenarios, one record per clock cycle.
    function automatic void build_directed();
        // 1: reset with run=1, then free-running ALU ops with zero-wait memory
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'h1, X_IDLE, 16'd0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 4'h1, X_IDLE, 16'd0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_IDLE, 16'd0, 1));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_FA, 16'(k), 1));
            tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_D,  16'(k), 1));
            tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_EA, 16'(k), 1));
            tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_I,  16'(k), 1));
        end
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'h1, X_FA, 16'd3, 1));
        // 2: single step, extra step during EXEC ignored
        tbl.push_back(mk(1, 1, 0, 0, 1, 4'h2, X_IDLE, 16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'h2, X_IDLE, 16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h2, X_FA,   16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h2, X_D,    16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'h2, X_EA,   16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h2, X_I,    16'd0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h2, X_IDLE, 16'd1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h2, X_IDLE, 16'd1, 2));
        // 3: memory op, 3 fetch waits, 2 exec waits, run dropped after fetch
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'h9, X_IDLE, 16'd0, 3));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 4'h9, X_F, 16'd0, 3));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'h9, X_FA, 16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h9, X_D,  16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h9, X_EM, 16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h9, X_EM, 16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h9, X_EM, 16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h9, X_I,  16'd0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h9, X_IDLE, 16'd1, 3));
        // 4: fetch timeout after 15 request cycles, sticky ERR, clear
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'h1, X_IDLE, 16'd0, 4));
        for (int k = 0; k < 15; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 4'h1, X_F, 16'd0, 4));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, logic'(k % 2), logic'(k % 2), logic'(k % 2), 4'h1, X_ERR, 16'd0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h1, X_ERR,  16'd0, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h1, X_IDLE, 16'd0, 4));
        // 5: HALT opcode, sticky with run=1 and step pulses
        tbl.push_back(mk(1, 1, 1, 0, 1, 4'hF, X_IDLE, 16'd0, 5));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'hF, X_FA,   16'd0, 5));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'hF, X_D,    16'd0, 5));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(0, 1, 1, logic'(k % 2), 1, 4'hF, X_H, 16'd0, 5));
    endfunction

    // Instruction-level model: each instruction is F x (waits+1), D,
    // E x (1 or waits+1), I; retired counts completed INCR phases.
    // Inputs the design must ignore in a phase are randomized.
    function automatic void gen_random(input int tid, input int n);
        int         cnt = 0;
        int         wf, we;
        logic [3:0] op;
        tbl.push_back(mk(1, 1, 1, 0, rbit(), 4'h0, X_IDLE, 16'd0, tid));
        for (int j = 0; j < n; j++) begin
            op = 4'($urandom_range(0, 14));
            wf = pick_wait();
            we = pick_wait();
            for (int k = 0; k <= wf; k++)
                tbl.push_back(mk(0, 1, rbit(), rbit(), logic'(k == wf), op,
                                 (k == wf) ? X_FA : X_F, 16'(cnt), tid));
            tbl.push_back(mk(0, 1, rbit(), rbit(), rbit(), op, X_D, 16'(cnt), tid));
            if (op[3]) begin
                for (int k = 0; k <= we; k++)
                    tbl.push_back(mk(0, 1, rbit(), rbit(), logic'(k == we), op, X_EM, 16'(cnt), tid));
            end else begin
                tbl.push_back(mk(0, 1, rbit(), rbit(), rbit(), op, X_EA, 16'(cnt), tid));
            end
            tbl.push_back(mk(0, 1, logic'(j != n - 1), rbit(), rbit(), op, X_I, 16'(cnt), tid));
            cnt++;
        end
        tbl.push_back(mk(0, 1, 0, 0, rbit(), 4'h0, X_IDLE, 16'(cnt), tid));
        tbl.push_back(mk(0, 1, 0, 0, rbit(), 4'h0, X_IDLE, 16'(cnt), tid));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0; run = 1'b0; step = 1'b0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [9:0] got;
        if (v.pre_rst) do_reset();
        @(negedge clk);
        clr_n = v.clr_n; run = v.run; step = v.step;
        bus.mem_ack = v.ack; bus.opcode = v.op;
        #1;
        got = {f, d, e, i, bus.mem_req, bus.ir_load, bus.pc_inc, busy, halted, err};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL t%0d vec%0d outputs got %b want %b", v.tid, idx, got, v.exp);
        end
        checks++;
        if (retired !== v.ret) begin
            errors++;
            $display("FAIL t%0d vec%0d retired got %h want %h", v.tid, idx, retired, v.ret);
        end
    endtask

    task automatic check_w(input logic [4:0] ex, input logic [1:0] rt, input int idx);
        checks++;
        if ({f_w, d_w, e_w, i_w, busy_w} !== ex) begin
            errors++;
            $display("FAIL wrap%0d phases got %b want %b", idx, {f_w, d_w, e_w, i_w, busy_w}, ex);
        end
        checks++;
        if (retired_w !== rt) begin
            errors++;
            $display("FAIL wrap%0d retired got %0d want %0d", idx, retired_w, rt);
        end
    endtask

    initial begin
        clr_n = 1'b0; run = 1'b0; step = 1'b0;
        bus.mem_ack = 1'b0; bus.opcode = 4'h0;
        clr_n_w = 1'b0; run_w = 1'b0; step_w = 1'b0;
        bus_w.mem_ack = 1'b0; bus_w.opcode = 4'h0;

        build_directed();
        for (int r = 0; r < 3; r++) gen_random(6 + r, 25);
        for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

        // 6: counter wrap on the 2-bit instance; run dropped in last EXEC
        @(negedge clk);
        clr_n_w = 1'b0; run_w = 1'b1; bus_w.mem_ack = 1'b1; bus_w.opcode = 4'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n_w = 1'b1;
        #1;
        check_w(5'b00000, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
                @(negedge clk);
                if (k == 3 && ph == 2) run_w = 1'b0;
                #1;
                check_w({4'b1000 >> ph, 1'b1}, 2'(k), 1 + 4 * k + ph);
            end
        end
        @(negedge clk);
        #1;
        check_w(5'b00000, 2'd0, 17);
        @(negedge clk);
        #1;
        check_w(5'b00000, 2'd0, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Control FSM that sequences the 3-stage processor through fetch, decode, execute and increment phases.
- Drives the phase strobes f/d/e/i.
- Handshakes with instruction/data memory and detects the HALT opcode.
- Supports free-run and single-step operation, and counts retired instructions.
- Sits between the front panel/testbench controls and the datapath (IR, PC, ALU enables).

Parameters:
OPW, 4, opcode width in bits.
HALT_OP, 4'hF, opcode that stops the sequencer.
TMO_W, 4, width of the memory-wait timeout counter; timeout fires after 2**TMO_W-1 = 15 wait cycles.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
clr_n  in  1  synchronous active-low reset.
run  in  1  level; 1 = continuous execution.
step  in  1  single-cycle pulse; execute exactly one instruction.
opcode  in  OPW  current IR opcode field; valid from DECODE onward.
mem_ack  in  1  memory completion, sampled only while mem_req=1.
mem_req  out  1  memory access request.
ir_load  out  1  load IR from memory bus.
pc_inc  out  1  increment PC.
f  out  1  fetch phase strobe.
d  out  1  decode phase strobe.
e  out  1  execute phase strobe.
i  out  1  increment phase strobe.
busy  out  1  1 in any state other than IDLE, HALT, ERR.
halted  out  1  HALT state.
err  out  1  memory timeout state.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (clr_n=0 at a clock edge):
  - State goes to IDLE; retired=0, timeout counter=0, step_mode=0.
  - Every output is 0.
  - Reset has priority over everything, including mid-instruction and HALT/ERR.
- States: IDLE, FETCH, DECODE, EXEC, INCR, HALT, ERR.
- Output decode:
  - f/d/e/i are one-hot decodes of FETCH/DECODE/EXEC/INCR.
  - All four are 0 in IDLE, HALT and ERR.
- IDLE:
  - run=1 → FETCH with step_mode=0.
  - Else step=1 → FETCH with step_mode=1.
  - run has priority when both are asserted.
- FETCH:
  - mem_req=1.
  - mem_ack=1 → ir_load=1 in that same cycle (combinational from state&mem_ack), timeout counter cleared, → DECODE.
  - mem_ack=0 → timeout counter increments. When it reaches 2**TMO_W-1 with ack still low → ERR.
- DECODE: one cycle.
  - opcode==HALT_OP → HALT; retired is not incremented for HALT.
  - Else → EXEC.
- EXEC:
  - opcode[OPW-1]==0 (ALU op): one cycle, → INCR.
  - opcode[OPW-1]==1 (memory op): mem_req=1, waits for mem_ack with the same timeout rule as FETCH, then → INCR.
  - ir_load stays 0 in EXEC.
- INCR: one cycle.
  - pc_inc=1; retired increments, wrapping from all-ones to 0.
  - Next: if run=1 and step_mode=0 → FETCH, else → IDLE and step_mode cleared.
- run deasserted mid-instruction: the current instruction completes through INCR, then IDLE. No abort.
- run asserted during a step-mode instruction: takes effect only at the next IDLE decision.
- step pulses outside IDLE are ignored.
- mem_ack while mem_req=0 is ignored.
- HALT: halted=1; stays until clr_n=0, ignoring run and step.
- ERR: err=1, mem_req=0; stays until clr_n=0.
- Latency:
  - Zero-wait memory (ack in the request cycle): ALU instruction = 4 cycles (F,D,E,I).
  - Memory instruction with zero wait = 4 cycles.
  - Each wait cycle adds 1.
- Timeout counter resets on every state entry.

Test Plan:
1. clr_n=0 for 2 cycles with run=1 → all outputs 0, retired=0. Release with mem_ack tied 1 and opcode=4'h1 → f,d,e,i each high exactly one cycle in order, repeating every 4 cycles; retired=3 after 12 cycles.
2. IDLE, run=0, one-cycle step pulse, opcode=4'h2, mem_ack=1 → exactly one F-D-E-I sequence, then IDLE, busy=0, retired=1. A step during E has no effect.
3. opcode=4'h9 (memory op), mem_ack delayed 3 cycles in FETCH and 2 cycles in EXEC → f high 4 cycles, e high 3 cycles, ir_load one pulse coincident with the first ack, instruction takes 9 cycles.
4. mem_ack held 0 in FETCH → mem_req high 15 cycles, then err=1, mem_req=0, busy=0. run toggling does nothing; clr_n=0 returns to IDLE with err=0.
5. opcode=HALT_OP (4'hF) → F, D, then halted=1, no e/i/pc_inc, retired unchanged. Remains halted with run=1 for 20 cycles.
6. Preload retired=16'hFFFE via run, drop run during EXEC → instruction finishes through INCR, retired wraps FFFF→0000 across two instructions, IDLE after INCR.
